// File: rtl/issue_scoreboard_ctrl_if.sv
// Decode-to-issue bundle: decoded operands and pipeline controls in, issue/stall/writeback controls out.
interface issue_scoreboard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    logic                  clk_en;
    logic                  icache_data_ready;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_writes;
    logic                  flush;
    logic                  issue;
    logic                  fetch_en;
    logic                  stall;
    logic                  wb_enable;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [NREGS-1:0]      busy_mask;

    modport master (
        output clk_en, icache_data_ready, id_valid, id_rs, id_rt, id_dst,
               id_uses_rs, id_uses_rt, id_writes, flush,
        input  issue, fetch_en, stall, wb_enable, wb_addr, busy_mask
    );

    modport slave (
        input  clk_en, icache_data_ready, id_valid, id_rs, id_rt, id_dst,
               id_uses_rs, id_uses_rt, id_writes, flush,
        output issue, fetch_en, stall, wb_enable, wb_addr, busy_mask
    );
endinterface

// File: rtl/issue_scoreboard_ctrl.sv
// Issue gate for decode->ALU: scoreboards pending regfile writes, stalls on RAW/WAW or icache not ready.
// Latency: issue is combinational; the regfile write lands EXEC_LAT+1 enabled edges after issue.
// Backpressure: stall/fetch_en hold decode and fetch; clk_en=0 freezes all state and write enables.
module issue_scoreboard_ctrl #(
    parameter int EXEC_LAT   = 1,
    parameter int REG_ADDR_W = 5
) (
    input logic                  clk,
    input logic                  rst,
    issue_scoreboard_ctrl_if.slave bus
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] dst;
    } slot_t;

    logic [NREGS-1:0]          busy_q, busy_d;
    slot_t [EXEC_LAT-1:0]      slot_q, slot_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0]     wb_addr_q, wb_addr_d;

    logic                      hazard;
    logic                      issue;
    logic                      stall;
    logic                      wb_en;
    logic [NREGS-1:0]          set_mask;
    logic [NREGS-1:0]          clr_mask;
    logic [NREGS-1:0]          busy_keep;

    always_comb begin
        hazard = (bus.id_uses_rs & busy_q[bus.id_rs])
               | (bus.id_uses_rt & busy_q[bus.id_rt])
               | (bus.id_writes  & busy_q[bus.id_dst]);
        // Reset edge must not report an issue the pipe is about to discard.
        issue  = ~rst & bus.clk_en & bus.id_valid & bus.icache_data_ready & ~hazard & ~bus.flush;
        stall  = bus.id_valid & (hazard | ~bus.icache_data_ready) & ~bus.flush;
        wb_en  = wb_valid_q & bus.clk_en;
    end

    assign bus.issue     = issue;
    assign bus.stall     = stall;
    assign bus.fetch_en  = bus.clk_en & ~stall;
    assign bus.wb_enable = wb_en;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.busy_mask = busy_q;

    always_comb begin
        set_mask = '0;
        if (issue && bus.id_writes && (bus.id_dst != '0))
            set_mask[bus.id_dst] = 1'b1;
        clr_mask = '0;
        if (wb_en)
            clr_mask[wb_addr_q] = 1'b1;
    end

    always_comb begin
        slot_d     = slot_q;
        busy_d     = busy_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        busy_keep  = busy_q;
        if (bus.clk_en) begin
            for (int i = EXEC_LAT - 1; i > 0; i--)
                slot_d[i] = slot_q[i-1];
            slot_d[0].vld = issue & bus.id_writes & (bus.id_dst != '0);
            slot_d[0].dst = issue ? bus.id_dst : '0;
            wb_valid_d    = slot_q[EXEC_LAT-1].vld & ~bus.flush;
            wb_addr_d     = slot_q[EXEC_LAT-1].dst;
            if (bus.flush) begin
                // The instruction already in writeback is past the flush point and still retires.
                slot_d    = '0;
                busy_keep = '0;
                if (wb_valid_q)
                    busy_keep[wb_addr_q] = busy_q[wb_addr_q];
            end
            busy_d = (busy_keep & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            slot_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
        end else begin
            busy_q     <= busy_d;
            slot_q     <= slot_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
        end
    end

    set_clr_collide: assert property (@(posedge clk) disable iff (rst) (set_mask & clr_mask) == '0);
endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Bench for issue_scoreboard_ctrl: EXEC_LAT=1 and EXEC_LAT=3 instances, directed issue stream plus writeback scoreboard.
module tb_issue_scoreboard_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_scoreboard_ctrl_if #(.REG_ADDR_W(AW)) bus1 ();
    issue_scoreboard_ctrl_if #(.REG_ADDR_W(AW)) bus3 ();

    issue_scoreboard_ctrl #(.EXEC_LAT(1), .REG_ADDR_W(AW)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    issue_scoreboard_ctrl #(.EXEC_LAT(3), .REG_ADDR_W(AW)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // sel picks the instance under stimulus; the other one sits idle with clk_en=1.
    logic          sel = 1'b0;
    logic          d_clk_en, d_ready, d_valid, d_urs, d_urt, d_wr, d_flush;
    logic [AW-1:0] d_rs, d_rt, d_dst;

    assign bus1.clk_en            = sel ? 1'b1 : d_clk_en;
    assign bus1.icache_data_ready = sel ? 1'b1 : d_ready;
    assign bus1.id_valid          = d_valid & ~sel;
    assign bus1.flush             = d_flush & ~sel;
    assign bus1.id_rs             = d_rs;
    assign bus1.id_rt             = d_rt;
    assign bus1.id_dst            = d_dst;
    assign bus1.id_uses_rs        = d_urs;
    assign bus1.id_uses_rt        = d_urt;
    assign bus1.id_writes         = d_wr;

    assign bus3.clk_en            = sel ? d_clk_en : 1'b1;
    assign bus3.icache_data_ready = sel ? d_ready : 1'b1;
    assign bus3.id_valid          = d_valid & sel;
    assign bus3.flush             = d_flush & sel;
    assign bus3.id_rs             = d_rs;
    assign bus3.id_rt             = d_rt;
    assign bus3.id_dst            = d_dst;
    assign bus3.id_uses_rs        = d_urs;
    assign bus3.id_uses_rt        = d_urt;
    assign bus3.id_writes         = d_wr;

    logic        o_issue, o_stall, o_fetch;
    logic [31:0] o_busy;
    assign o_issue = sel ? bus3.issue     : bus1.issue;
    assign o_stall = sel ? bus3.stall     : bus1.stall;
    assign o_fetch = sel ? bus3.fetch_en  : bus1.fetch_en;
    assign o_busy  = sel ? bus3.busy_mask : bus1.busy_mask;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } wb_exp_t;

    wb_exp_t q1[$];
    wb_exp_t q3[$];
    int      cyc = 0;
    logic    mon_on = 1'b0;
    logic    e1, e3;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle, each instance must write exactly when the oldest expected writeback is due.
    always @(negedge clk) begin
        if (mon_on) begin
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            chk_eq("wb_enable L1", {31'b0, bus1.wb_enable}, {31'b0, e1});
            if (e1) begin
                chk_eq("wb_addr L1", {27'b0, bus1.wb_addr}, {27'b0, q1[0].addr});
                void'(q1.pop_front());
            end
            e3 = (q3.size() > 0) && (q3[0].due == cyc);
            chk_eq("wb_enable L3", {31'b0, bus3.wb_enable}, {31'b0, e3});
            if (e3) begin
                chk_eq("wb_addr L3", {27'b0, bus3.wb_addr}, {27'b0, q3[0].addr});
                void'(q3.pop_front());
            end
        end
    end

    task automatic push_wb(input logic [AW-1:0] a, input int due);
        wb_exp_t e;
        e.addr = a;
        e.due  = due;
        if (sel) q3.push_back(e);
        else     q1.push_back(e);
    endtask

    // Present one instruction, expect `stalls` blocked cycles, then issue with the given busy mask.
    task automatic issue_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] dst,
                               input logic urs, input logic urt, input logic wr,
                               input int stalls, input logic [31:0] exp_busy);
        d_valid = 1'b1;
        d_rs = rs; d_rt = rt; d_dst = dst;
        d_urs = urs; d_urt = urt; d_wr = wr;
        for (int n = 0; n <= stalls; n++) begin
            @(negedge clk);
            if (n < stalls) begin
                chk_eq("stall on hazard", {31'b0, o_stall}, 32'd1);
                chk_eq("issue held",      {31'b0, o_issue}, 32'd0);
                chk_eq("fetch_en held",   {31'b0, o_fetch}, 32'd0);
            end else begin
                chk_eq("issue",        {31'b0, o_issue}, 32'd1);
                chk_eq("stall clear",  {31'b0, o_stall}, 32'd0);
                chk_eq("busy at issue", o_busy, exp_busy);
                if (wr && dst != '0)
                    push_wb(dst, cyc + 2 + (sel ? 2 : 0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        d_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        d_clk_en = 1'b1; d_ready = 1'b1; d_flush = 1'b0;
        d_valid = 1'b1; d_rs = '0; d_rt = '0; d_dst = 5'd1;
        d_urs = 1'b0; d_urt = 1'b0; d_wr = 1'b1;

        // Reset held two edges with a ready instruction in decode.
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(negedge clk);
        chk_eq("reset issue", {31'b0, o_issue}, 32'd0);
        chk_eq("reset stall", {31'b0, o_stall}, 32'd0);
        chk_eq("reset busy",  o_busy, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue_instr(5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        // RAW on r3 with EXEC_LAT=1: two stall cycles, r3 written during the second.
        issue_instr(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 0, 32'h2);
        issue_instr(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2, 32'h0);
        // r0 never goes busy; WAW on r5.
        issue_instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        issue_instr(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        issue_instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        issue_instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 2, 32'h0);

        // Freeze three cycles while r2 sits in writeback; decode reads r2.
        issue_instr(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 0, 32'h20);
        d_valid = 1'b0;
        @(posedge clk); #1;
        d_valid = 1'b1; d_rs = 5'd2; d_urs = 1'b1; d_dst = 5'd9; d_wr = 1'b1;
        d_clk_en = 1'b0;
        repeat (3) begin
            foreach (q1[i]) q1[i].due++;
            @(negedge clk);
            chk_eq("frozen issue",    {31'b0, o_issue}, 32'd0);
            chk_eq("frozen fetch_en", {31'b0, o_fetch}, 32'd0);
            chk_eq("frozen stall",    {31'b0, o_stall}, 32'd1);
            chk_eq("frozen busy",     o_busy, 32'h4);
            @(posedge clk); #1;
        end
        d_clk_en = 1'b1;
        issue_instr(5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1, 32'h0);

        // icache not ready blocks an otherwise free instruction.
        d_ready = 1'b0;
        d_urs = 1'b0; d_dst = 5'd10;
        @(negedge clk);
        chk_eq("icache stall",    {31'b0, o_stall}, 32'd1);
        chk_eq("icache fetch_en", {31'b0, o_fetch}, 32'd0);
        chk_eq("icache issue",    {31'b0, o_issue}, 32'd0);
        @(posedge clk); #1;
        d_ready = 1'b1;
        issue_instr(5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, 0, 32'h200);

        // Reset while r10 is still in execute: its writeback must never appear.
        rst = 1'b1;
        d_valid = 1'b0;
        q1.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("busy after mid reset", o_busy, 32'h0);
        @(posedge clk); #1;
        idle(3);

        // EXEC_LAT=3: independent stream, then flush with r6 in writeback.
        sel = 1'b1;
        issue_instr(5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        issue_instr(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 0, 32'h2);
        issue_instr(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 0, 32'h6);
        d_valid = 1'b0;
        @(negedge clk);
        chk_eq("busy peak", o_busy, 32'h16);
        @(posedge clk); #1;
        idle(6);

        issue_instr(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        issue_instr(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 0, 32'h40);
        issue_instr(5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 0, 32'hC0);
        d_valid = 1'b0;
        @(negedge clk);
        chk_eq("busy before flush", o_busy, 32'h1C0);
        @(posedge clk); #1;
        d_flush = 1'b1;
        d_valid = 1'b1; d_dst = 5'd11; d_wr = 1'b1;
        while (q3.size() > 1) void'(q3.pop_back());
        @(negedge clk);
        chk_eq("issue under flush", {31'b0, o_issue}, 32'd0);
        chk_eq("stall under flush", {31'b0, o_stall}, 32'd0);
        chk_eq("busy at flush",     o_busy, 32'h1C0);
        @(posedge clk); #1;
        d_flush = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        chk_eq("busy after flush", o_busy, 32'h0);
        @(posedge clk); #1;
        idle(6);

        chk_eq("L1 writebacks drained", q1.size(), 32'd0);
        chk_eq("L3 writebacks drained", q3.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard_ctrl.md
Name: issue_scoreboard_ctrl

Overview:
Issue controller for the core's fetch/decode/execute/writeback pipeline. It decides each cycle whether the decoded instruction may issue to the ALU. It tracks pending register-file writes in a scoreboard and stalls on RAW and WAW hazards or when the icache is not ready. It also sequences the regfile write port (enable and address) and drives the fetch-stage advance.

Parameters:
EXEC_LAT, 1, cycles an issued instruction spends in execute before writeback; legal range 1..4
REG_ADDR_W, 5, register address width; NREGS = 2**REG_ADDR_W

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
clk_en  in  1  global pipeline advance; when low, all state holds
icache_data_ready  in  1  fetched instruction word is valid
id_valid  in  1  decode stage holds an instruction
id_rs  in  REG_ADDR_W  source register a
id_rt  in  REG_ADDR_W  source register b
id_dst  in  REG_ADDR_W  destination register
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_writes  in  1  instruction writes id_dst
flush  in  1  cancel the decode instruction and all execute-stage instructions
issue  out  1  decode instruction enters execute at this edge
fetch_en  out  1  PC/icache advance enable
stall  out  1  decode instruction blocked
wb_enable  out  1  regfile write enable
wb_addr  out  REG_ADDR_W  regfile write address
busy_mask  out  NREGS  scoreboard; bit i set means register i has a pending write

Behaviour:
- State elements:
  - busy[NREGS-1:0].
  - Execute shift pipe of EXEC_LAT slots, each holding {valid, dst}.
  - wb_valid_q and wb_addr_q.
- All state updates only at a posedge with clk_en=1 (or with rst=1).
- Reset (rst=1 at posedge, overrides clk_en):
  - busy=0; all slots invalid with dst=0; wb_valid_q=0; wb_addr=0.
  - Resulting outputs: issue=0, stall=0, wb_enable=0, busy_mask=0.
- hazard = (id_uses_rs & busy[id_rs]) | (id_uses_rt & busy[id_rt]) | (id_writes & busy[id_dst]).
- busy[0] is never set, so register 0 never causes a hazard.
- Combinational outputs:
  - issue = clk_en & id_valid & icache_data_ready & ~hazard & ~flush.
  - stall = id_valid & (hazard | ~icache_data_ready) & ~flush.
  - fetch_en = clk_en & ~stall.
  - wb_enable = wb_valid_q & clk_en. Gating prevents a duplicate write while the pipe is frozen.
  - wb_addr = wb_addr_q.
- Per enabled edge:
  - Slots shift toward writeback.
  - slot[0] <= issue ? {id_writes & (id_dst!=0), id_dst} : {0, 0}.
  - {wb_valid_q, wb_addr_q} <= slot[EXEC_LAT-1].
- Busy update:
  - On issue with a writing, nonzero dst: set busy[id_dst].
  - When wb_enable=1: clear busy[wb_addr].
  - If set and clear target the same register at the same edge, set wins. WAW blocking makes this unreachable; an assertion checks it.
- Latency:
  - Independent instructions issue back-to-back with no bubble.
  - The regfile write occurs EXEC_LAT+1 edges after the issue edge.
  - A RAW-dependent consumer issues EXEC_LAT+2 edges after its producer and sees stall=1 for EXEC_LAT+1 cycles. There is no forwarding.
- flush at an enabled edge:
  - All slots are invalidated.
  - busy is cleared except busy[wb_addr_q] when wb_valid_q=1; that writeback still completes.
  - The decode instruction does not issue.
- clk_en=0:
  - issue=0, fetch_en=0, wb_enable=0.
  - busy, slots and wb_q hold; stall still reflects the hazard.
- Reset mid-operation discards all pending writebacks; no wb_enable pulse follows.

Test Plan:
1. Reset: rst=1 for 2 cycles with id_valid=1 -> busy_mask=0, wb_enable=0, issue=0; first edge after release with no hazard -> issue=1.
2. RAW, EXEC_LAT=1: producer writes r3 issued at edge E0; next instruction reads r3 held in decode -> stall=1 during E0-E1 and E1-E2; wb_enable=1, wb_addr=3 during E1-E2; issue=1 sampled at E3.
3. Independent stream: dsts r1, r2, r4 on consecutive edges, no shared sources -> issue=1 every cycle; wb_addr sequence 1, 2, 4 on consecutive cycles; busy_mask peaks at 0x16.
4. Register 0 and WAW: write r0, then read r0 -> no stall, busy_mask=0, wb_enable stays 0; write r5 twice back-to-back -> second stalls until busy[5] clears.
5. Freeze and ready: clk_en=0 for 3 cycles with wb_valid_q=1 -> wb_enable=0 and state unchanged, then exactly one write pulse; icache_data_ready=0 -> stall=1, fetch_en=0.
6. Flush, EXEC_LAT=3: r6, r7, r8 issued, then flush with r6 in the wb slot -> r6 still written, busy_mask=0 after the next edge, r7/r8 are never written.
